// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - two-requester arbiter for the Polilock password memory; hold timeout enabled by POLILOCK_ARB_TIMEOUT_EN
module arbitro_memoria #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              done0,
    input  logic              done1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              timeout,
    output logic              timeout_src,
    output logic [3:0]        db_estado
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] DONO0  = 2'd1;
    localparam logic [1:0] DONO1  = 2'd2;
    localparam logic [1:0] PAUSA  = 2'd3;

    logic [1:0] estado;
    logic [1:0] proximo;
    logic       ultimo;
    logic       liberou;
    logic       expirou;

    // The verification path is read-only, so we0 never reaches the memory.
    logic unused_ok;
    assign unused_ok = we0 ^ (TIMEOUT != 0);

    assign liberou = (estado == DONO0) ? (done0 || !req0) :
                     (estado == DONO1) ? (done1 || !req1) : 1'b0;

`ifdef POLILOCK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    logic [CW-1:0] contador;

    assign expirou = ((estado == DONO0) || (estado == DONO1)) && (contador == LIMITE);

    // Entry to DONOx is always from OCIOSO, where the counter sits at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador    <= '0;
            timeout     <= 1'b0;
            timeout_src <= 1'b0;
        end else begin
            contador <= ((estado == DONO0) || (estado == DONO1)) ? contador + 1'b1 : '0;
            timeout  <= 1'b0;
            if (expirou && !liberou) begin
                timeout     <= 1'b1;
                timeout_src <= (estado == DONO1);
            end
        end
    end
`else
    assign expirou     = 1'b0;
    assign timeout     = 1'b0;
    assign timeout_src = 1'b0;
`endif

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (req0 && req1)
                    proximo = ultimo ? DONO0 : DONO1;
                else if (req0)
                    proximo = DONO0;
                else if (req1)
                    proximo = DONO1;
            end
            DONO0, DONO1: begin
                if (liberou || expirou)
                    proximo = PAUSA;
            end
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            ultimo <= 1'b1;
        end else begin
            estado <= proximo;
            if (proximo == PAUSA && estado != PAUSA)
                ultimo <= (estado == DONO1);
        end
    end

    // Grants decode straight from the state register so reset drops them immediately.
    assign gnt0      = (estado == DONO0);
    assign gnt1      = (estado == DONO1);
    assign db_estado = {2'b00, estado};

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - directed scoreboard bench for arbitro_memoria
module tb_arbitro_memoria;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1, done0, done1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, mem_we, timeout, timeout_src;
    logic [3:0] mem_addr, mem_wdata, db_estado;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    arbitro_memoria #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .done0(done0), .done1(done1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .timeout(timeout), .timeout_src(timeout_src), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            e.tag = "sb_empty";
            e.val = 32'hdead_beef;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.val) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    task automatic wait_gnt1(input int budget);
        int n = 0;
        while (gnt1 !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        {req0, req1, done0, done1, we0, we1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        tick();
        tick();
        expect_val("rst_gnt", 0);       check({gnt0, gnt1});
        expect_val("rst_mem_we", 0);    check(mem_we);
        expect_val("rst_mem_addr", 0);  check(mem_addr);
        expect_val("rst_mem_wdata", 0); check(mem_wdata);
        expect_val("rst_timeout", 0);   check({timeout, timeout_src});
        expect_val("rst_db", 0);        check(db_estado);

        reset = 1'b1;
        tick();
        // Single request: read path with we0 masked.
        req0 = 1; addr0 = 4'd5; we0 = 1; wdata0 = 4'd3;
        expect_val("t1_gnt", 2'b10);
        expect_val("t1_addr", 5);
        expect_val("t1_we_masked", 0);
        expect_val("t1_db", 1);
        tick();
        check({gnt0, gnt1}); check(mem_addr); check(mem_we); check(db_estado);
        done0 = 1;
        expect_val("t1_rel_gnt", 0);
        expect_val("t1_pausa", 3);
        tick();
        check({gnt0, gnt1}); check(db_estado);
        done0 = 0; req0 = 0; we0 = 0;
        expect_val("t1_ocioso", 0);
        tick();
        check(db_estado);

        // Simultaneous requests after a fresh reset: requester 0 wins.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req0 = 1; req1 = 1; addr1 = 4'd2; wdata1 = 4'hA; we1 = 1;
        expect_val("t2_tie_gnt", 2'b10);
        tick();
        check({gnt0, gnt1});
        done0 = 1;
        expect_val("t2_pausa_gnt", 0);
        expect_val("t2_pausa_db", 3);
        tick();
        check({gnt0, gnt1}); check(db_estado);
        done0 = 0; req0 = 0;
        expect_val("t2_ocioso_gnt", 0);
        tick();
        check({gnt0, gnt1});
        expect_val("t2_gnt1", 2'b01);
        expect_val("t2_mem_we", 1);
        expect_val("t2_mem_wdata", 4'hA);
        expect_val("t2_mem_addr", 2);
        tick();
        check({gnt0, gnt1}); check(mem_we); check(mem_wdata); check(mem_addr);

        // Alternation while both keep requesting.
        req0 = 1;
        for (int r = 0; r < 3; r++) begin
            done1 = 1;
            tick();
            done1 = 0;
            tick();
            expect_val($sformatf("alt%0d_gnt0", r), 2'b10);
            tick();
            check({gnt0, gnt1});
            done0 = 1;
            tick();
            done0 = 0;
            tick();
            expect_val($sformatf("alt%0d_gnt1", r), 2'b01);
            tick();
            check({gnt0, gnt1});
        end

        // Abandonment by requester 1, then by requester 0.
        req1 = 0;
        expect_val("aband1_db", 3);
        expect_val("aband1_timeout", 0);
        tick();
        check(db_estado); check(timeout);
        tick();
        expect_val("aband0_pre_gnt", 2'b10);
        tick();
        check({gnt0, gnt1});
        req0 = 0;
        expect_val("aband0_gnt", 0);
        expect_val("aband0_db", 3);
        expect_val("aband0_timeout", 0);
        tick();
        check({gnt0, gnt1}); check(db_estado); check(timeout);
        tick();

        // Hold without release.
        req1 = 1; we1 = 1;
        tick();
        n = 0;
        while (gnt1 === 1'b1 && n < 200) begin
            tick();
            n++;
        end
`ifdef POLILOCK_ARB_TIMEOUT_EN
        expect_val("hold_cycles", 8);
        check(n);
        expect_val("to_pulse", 2'b11);
        check({timeout, timeout_src});
        expect_val("to_one_cycle", 0);
        tick();
        check(timeout);
`else
        expect_val("hold_past_100", 1);
        check(n > 100);
        expect_val("no_timeout", 0);
        check({timeout, timeout_src});
`endif

        // Reset in the middle of a writing grant.
        wait_gnt1(20);
        expect_val("pre_rst_gnt1", 1);
        expect_val("pre_rst_we", 1);
        check(gnt1); check(mem_we);
        reset = 1'b0;
        #1;
        expect_val("mid_rst_gnt", 0);
        expect_val("mid_rst_we", 0);
        expect_val("mid_rst_db", 0);
        expect_val("mid_rst_tsrc", 0);
        check({gnt0, gnt1}); check(mem_we); check(db_estado); check(timeout_src);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Arbiter that lets two requesters share the single-port password memory of the Polilock datapath. Requester 0 is the verification sequencer, which reads stored digits while checking an entry. Requester 1 is the password-change sequencer, which reads and writes. The block sits between both sequencers and the memory port. It grants exclusive ownership, muxes address, write data and write enable, and reclaims a grant when its owner stalls.

## Interface
Parameters:
- `ADDR_W`, default 4: memory address width.
- `DATA_W`, default 4: memory data width.
- `TIMEOUT`, default 64: maximum cycles one grant may be held; legal range 2..255.

Ports:
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req0`, `req1`, in, 1 each: access request, level, held until `done`.
- `done0`, `done1`, in, 1 each: one-cycle release pulse from the current owner.
- `addr0`, `addr1`, in, `ADDR_W` each: requester addresses.
- `wdata0`, `wdata1`, in, `DATA_W` each: requester write data.
- `we0`, `we1`, in, 1 each: requester write enables.
- `gnt0`, `gnt1`, out, 1 each: registered grants, one-hot or zero.
- `mem_addr`, out, `ADDR_W`: muxed address to memory.
- `mem_wdata`, out, `DATA_W`: muxed write data to memory.
- `mem_we`, out, 1: muxed write enable to memory.
- `timeout`, out, 1: one-cycle pulse when a grant is revoked.
- `timeout_src`, out, 1: owner that was revoked; held until the next revocation.
- `db_estado`, out, 4: FSM state code for the hexa7seg debug display.

## Operation
FSM states and codes:
- OCIOSO (0): no grant held.
- DONO0 (1): requester 0 owns the memory.
- DONO1 (2): requester 1 owns the memory.
- PAUSA (3): one-cycle turnaround after a release.

Transitions:
- OCIOSO: one request pending → grant that requester. Both pending → grant the requester that is not `ultimo`. `ultimo` records the last owner and resets to 1, so requester 0 wins the first tie.
- DONOx → PAUSA on any of: `donex`=1, `reqx`=0 (abandonment, treated as release), or timeout. `ultimo` is updated to x on exit.
- PAUSA → OCIOSO unconditionally. Pending requests are arbitrated on the next cycle, so no requester can hold ownership back-to-back while the other is waiting.

Mux rules:
- `mem_addr`, `mem_wdata` and `mem_we` come from the granted requester, combinationally from the registered state.
- No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `we0` is always masked to 0. The verification path is read-only.
- A `done` or `we` from a non-owner is ignored.

Hold counter:
- Counter of ceil(log2(TIMEOUT+1)) bits clears on entry to DONOx and increments each cycle in DONOx.
- When the count reaches `TIMEOUT`-1 without a release, the FSM exits to PAUSA. `timeout` pulses in the PAUSA cycle and `timeout_src`=x.
- If a release and the timeout occur in the same cycle, the release wins and `timeout` is not pulsed.

## Timing
- Reset values: state OCIOSO, `gnt0`=`gnt1`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `timeout`=0, `timeout_src`=0, `ultimo`=1, counter 0, `db_estado`=0.
- Grant latency: `req` seen high at edge N in OCIOSO → `gnt` high after edge N.
- Release: `done` high at edge N → `gnt` low after N, PAUSA for one cycle, next grant no earlier than after N+2.
- Maximum ownership: exactly `TIMEOUT` cycles of `gnt` high.
- Reset mid-grant: grants and `mem_we` drop immediately, without waiting for a clock edge.

## Configuration
- `POLILOCK_ARB_TIMEOUT_EN` defined: the hold counter, `timeout` and `timeout_src` are implemented as described above.
- Not defined: the counter is removed and a grant is held until `done` or `req` deassertion. `timeout` and `timeout_src` are tied to 0, and the `TIMEOUT` parameter is ignored.

## Test plan
- Reset, then `req0`=1 alone: `gnt0`=1 one cycle later. `addr0`=5 appears on `mem_addr`. `we0`=1 still gives `mem_we`=0.
- `req0` and `req1` rise in the same cycle after reset: requester 0 is granted. After `done0`, one PAUSA cycle, then `gnt1`=1. `wdata1`=A, `we1`=1 gives `mem_we`=1, `mem_wdata`=A.
- Requester 1 keeps `req1` high and issues `done1` repeatedly while `req0` is pending: grants alternate between 1 and 0 and never go to 1 twice in a row.
- With `TIMEOUT`=8 and the macro defined, `req1` is held without `done1`: `gnt1` stays high exactly 8 cycles, then `timeout`=1 for one cycle with `timeout_src`=1. With the macro undefined, `gnt1` stays high past 100 cycles.
- `reset` driven low while `gnt1`=1 and `mem_we`=1: both go to 0 immediately, and `db_estado`=0.
- `req0` dropped without `done0`: ownership is released, PAUSA follows, and `timeout`=0.
